// File: rtl/barrett_reduce_pipe_pkg.sv
// Shared constants for the Barrett reduction pipeline.
//
// DATA_SIZE   : default modulus width K (q must satisfy 2^(K-1) <= q < 2^K)
// BARRETT_LAT : operand latency in cycles, input valid to output valid
// MU_W        : width of the Barrett constant mu = floor(2^(2K)/q)
// R0_W        : width of the partial remainder r0, which is always < 3q
package barrett_reduce_pipe_pkg;

  localparam int DATA_SIZE   = 32;
  localparam int BARRETT_LAT = 4;
  localparam int MU_W        = DATA_SIZE + 1;
  localparam int R0_W        = DATA_SIZE + 2;

endpackage

// File: rtl/barrett_reduce_pipe_cond_sub.sv
// barrett_cond_sub: final correction step of Barrett reduction.
// Takes the partial remainder r0 (0 <= r0 < 3q) and subtracts q at most twice
// to land in [0, q). Purely combinational.
//
// Ports:
//   r0 [DW+1:0] in   partial remainder
//   q  [DW-1:0] in   modulus
//   r  [DW-1:0] out  fully reduced remainder
module barrett_cond_sub #(
  parameter int DW = 32
) (
  input  logic [DW+1:0] r0,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] r
);

  logic [DW+1:0] q_ext;
  logic [DW+1:0] t1;
  logic [DW+1:0] t2;
  logic          unused_t2_hi;

  always_comb begin
    q_ext = {2'b00, q};
    t1    = r0;
    if (t1 >= q_ext) begin
      t1 = t1 - q_ext;
    end
    t2 = t1;
    if (t2 >= q_ext) begin
      t2 = t2 - q_ext;
    end
    // After two corrections t2 < q < 2^DW, so the top two bits are zero.
    r = t2[DW-1:0];
  end

  assign unused_t2_hi = ^t2[DW+1:DW];

endmodule

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe: fully pipelined Barrett modular reducer, R = P mod q.
// Accepts one 2*DW-bit product per cycle, returns the DW-bit remainder four
// cycles later. No backpressure.
//
// Handshake: valid-only streaming. A beat is transferred on every posedge where
// in_valid is high; there is no ready, the pipeline always accepts. out_valid
// is high for exactly one cycle per accepted beat, BARRETT_LAT cycles later,
// in order. out_data (and out_tag) hold their last value while out_valid is low.
//
// Optional feature macro: BARRETT_TAG_EN adds in_tag/out_tag sideband ports
// (TAG_W bits) that travel alongside the operand with identical latency.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   cfg_we              1-cycle strobe to load cfg_q / cfg_mu
//   cfg_q [DW-1:0]      modulus q
//   cfg_mu [DW:0]       mu = floor(2^(2*DW)/q), computed by software
//   cfg_err             1-cycle pulse: a cfg_we was rejected (busy or in_valid)
//   busy                some operand is in flight
//   in_valid, in_data   operand P (2*DW bits)
//   out_valid, out_data remainder R (DW bits)
module barrett_reduce_pipe
  import barrett_reduce_pipe_pkg::*;
#(
  parameter int DW = DATA_SIZE
`ifdef BARRETT_TAG_EN
  , parameter int TAG_W = 8
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [DW-1:0]     cfg_q,
  input  logic [DW:0]       cfg_mu,
  output logic              cfg_err,
  output logic              busy,
  input  logic              in_valid,
  input  logic [2*DW-1:0]   in_data,
  output logic              out_valid,
  output logic [DW-1:0]     out_data
`ifdef BARRETT_TAG_EN
  ,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [TAG_W-1:0]  out_tag
`endif
);

  localparam int MW = 2*DW + 2;  // q1*mu product width
  localparam int QW = DW + 1;    // width of q1 and q3
  localparam int RW = DW + 2;    // width of the working remainder

  logic [DW-1:0] q_reg;
  logic [DW:0]   mu_reg;
  logic          cfg_accept;

  logic          s1_valid;
  logic [MW-1:0] s1_m1;
  logic [RW-1:0] s1_plo;

  logic          s2_valid;
  logic [RW-1:0] s2_m2;
  logic [RW-1:0] s2_plo;

  logic          s3_valid;
  logic [RW-1:0] s3_r0;

  logic [QW-1:0] q1;
  logic [QW-1:0] q3;
  (* use_dsp = "yes" *) logic [MW-1:0] m1;
  (* use_dsp = "yes" *) logic [RW-1:0] m2;
  logic [DW-1:0] r_sub;
  logic          unused_m1_lo;

  assign busy = s1_valid | s2_valid | s3_valid | out_valid;

  // The modulus may only change while nothing is in flight and nothing is
  // arriving, so every operand is reduced with a single consistent q/mu.
  assign cfg_accept = cfg_we & ~busy & ~in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg   <= '0;
      mu_reg  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & ~cfg_accept;
      if (cfg_accept) begin
        q_reg  <= cfg_q;
        mu_reg <= cfg_mu;
      end
    end
  end

  // S1: estimate quotient numerator. Only the low DW+2 bits of P are needed
  // later, because the true remainder and the error term both fit there.
  assign q1 = in_data[2*DW-1:DW-1];
  assign m1 = MW'(q1) * MW'(mu_reg);

  // S2: quotient estimate times q, truncated to the working width.
  assign q3 = s1_m1[MW-1:DW+1];
  assign m2 = RW'(q3) * RW'(q_reg);
  assign unused_m1_lo = ^s1_m1[DW:0];

  barrett_cond_sub #(
    .DW (DW)
  ) u_cond_sub (
    .r0 (s3_r0),
    .q  (q_reg),
    .r  (r_sub)
  );

  // Data registers only load when their incoming stage is valid, so the
  // output holds the last result between samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_m1     <= '0;
      s1_plo    <= '0;
      s2_valid  <= 1'b0;
      s2_m2     <= '0;
      s2_plo    <= '0;
      s3_valid  <= 1'b0;
      s3_r0     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
      if (in_valid) begin
        s1_m1  <= m1;
        s1_plo <= in_data[RW-1:0];
      end
      if (s1_valid) begin
        s2_m2  <= m2;
        s2_plo <= s1_plo;
      end
      if (s2_valid) begin
        // Modular subtraction in RW bits; the result is known to be < 3q.
        s3_r0 <= s2_plo - s2_m2;
      end
      if (s3_valid) begin
        // With no modulus loaded the datapath output is meaningless; force 0.
        out_data <= (q_reg == '0) ? '0 : r_sub;
      end
    end
  end

`ifdef BARRETT_TAG_EN
  logic [TAG_W-1:0]       tag_pipe [BARRETT_LAT];
  logic [BARRETT_LAT-1:0] tag_ld;

  assign tag_ld = {s3_valid, s2_valid, s1_valid, in_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BARRETT_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      if (tag_ld[0]) begin
        tag_pipe[0] <= in_tag;
      end
      for (int i = 1; i < BARRETT_LAT; i++) begin
        if (tag_ld[i]) begin
          tag_pipe[i] <= tag_pipe[i-1];
        end
      end
    end
  end

  assign out_tag = tag_pipe[BARRETT_LAT-1];
`endif

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Testbench for barrett_reduce_pipe (DW = 32). Reference model: P % q with
// plain wide arithmetic, mu computed as floor(2^64 / q).
// Define BARRETT_TAG_EN to also exercise the tag sideband.
module tb_barrett_reduce_pipe;

  localparam int DW = 32;
  localparam logic [DW-1:0] QA = 32'hFFFF_FFFB;
  localparam logic [DW-1:0] QB = 32'h8000_0011;

  // clock / reset
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0;
  logic [DW-1:0]     cfg_q = '0;
  logic [DW:0]       cfg_mu = '0;
  logic              cfg_err;
  logic              busy;
  logic              in_valid = 1'b0;
  logic [2*DW-1:0]   in_data = '0;
  logic              out_valid;
  logic [DW-1:0]     out_data;
`ifdef BARRETT_TAG_EN
  logic [7:0]        in_tag = '0;
  logic [7:0]        out_tag;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [DW-1:0] model_q = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  barrett_reduce_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_q     (cfg_q),
    .cfg_mu    (cfg_mu),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef BARRETT_TAG_EN
    ,
    .in_tag    (in_tag),
    .out_tag   (out_tag)
`endif
  );

  // reference model
  function automatic logic [DW-1:0] ref_mod(input logic [2*DW-1:0] p, input logic [DW-1:0] q);
    logic [2*DW-1:0] r;
    if (q == '0) return '0;
    r = p % {{DW{1'b0}}, q};
    return r[DW-1:0];
  endfunction

  function automatic logic [DW:0] ref_mu(input logic [DW-1:0] q);
    logic [2*DW:0] num;
    logic [2*DW:0] res;
    num = '0;
    num[2*DW] = 1'b1;
    res = num / {{(DW+1){1'b0}}, q};
    return res[DW:0];
  endfunction

  function automatic logic [2*DW-1:0] rand_p();
    return {$urandom(), $urandom()};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic load_cfg(input logic [DW-1:0] q);
    cfg_we = 1'b1;
    cfg_q  = q;
    cfg_mu = ref_mu(q);
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_load_err: got %b want 0", cfg_err);
    end
    model_q = q;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
    reset = 1'b0;
    model_q = '0;
    tick();
  endtask

  task automatic test_unconfigured(input string name);
    logic [2*DW-1:0] p;
    bit ok;
    p = rand_p();
    in_valid = 1'b1;
    in_data  = p;
    tick();
    in_valid = 1'b0;
    wait_out(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: got no out_valid want out_valid", name); end
    checks++;
    if (out_data !== ref_mod(p, model_q)) begin
      errors++;
      $display("FAIL %s_data: got %h want %h", name, out_data, ref_mod(p, model_q));
    end
    repeat (2) tick();
  endtask

  task automatic test_latency();
    bit exp_busy;
    bit exp_ov;
    load_cfg(QA);
    in_valid = 1'b1;
    in_data  = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      in_valid = 1'b0;
      exp_busy = (i <= 4);
      exp_ov   = (i == 4);
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL latency_busy t+%0d: got %b want %b", i, busy, exp_busy); end
      checks++;
      if (out_valid !== exp_ov) begin errors++; $display("FAIL latency_out_valid t+%0d: got %b want %b", i, out_valid, exp_ov); end
      if (i == 4) begin
        checks++;
        if (out_data !== '0) begin errors++; $display("FAIL latency_data: got %h want 0", out_data); end
      end
    end
  endtask

  // Streams pv back-to-back and checks every output cycle against ev with a
  // scoreboard of (due cycle, expected value).
  task automatic test_stream(input string name, input logic [2*DW-1:0] pv[$], input logic [DW-1:0] ev[$]);
    logic [DW-1:0] exp_q[$];
    int            due_q[$];
    int            n;
    bit            exp_v;
    logic [DW-1:0] e;
    n = pv.size();
    for (int c = 0; c < n + 6; c++) begin
      if (c < n) begin
        in_valid = 1'b1;
        in_data  = pv[c];
        exp_q.push_back(ev[c]);
        due_q.push_back(cyc + 4);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL %s_valid step %0d: got %b want %b", name, c, out_valid, exp_v);
      end
      if (exp_v) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        checks++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL %s_data step %0d: got %h want %h", name, c, out_data, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d outstanding want 0", name, exp_q.size());
    end
  endtask

  task automatic test_known();
    logic [2*DW-1:0] pv[$];
    logic [DW-1:0]   ev[$];
    pv = '{64'(QA) * 64'(QA) - 64'd1, 64'(QA), 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd7, 64'(QA) - 64'd1};
    ev = '{32'hFFFF_FFFA, 32'h0, 32'h5, 32'h18, 32'h7, 32'hFFFF_FFFA};
    test_stream("known", pv, ev);
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] pv[$];
    logic [DW-1:0]   ev[$];
    logic [2*DW-1:0] p;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 7))
        0:       p = 64'(model_q) - 64'(1 + $urandom_range(0, 3));
        1:       p = ~64'(0) - 64'($urandom_range(0, 255));
        2:       p = 64'(model_q) * 64'($urandom());
        default: p = rand_p();
      endcase
      pv.push_back(p);
      ev.push_back(ref_mod(p, model_q));
    end
    test_stream("b2b", pv, ev);
  endtask

  task automatic test_cfg_busy();
    logic [2*DW-1:0] p;
    logic [DW-1:0]   e;
    bit              ok;
    // rejected while busy
    p = rand_p();
    in_valid = 1'b1;
    in_data  = p;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_q  = QB;
    cfg_mu = ref_mu(QB);
    tick();
    cfg_we = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_busy_err: got %b want 1", cfg_err); end
    tick();
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse: got %b want 0", cfg_err); end
    wait_out(ok);
    e = ref_mod(p, model_q);
    checks++;
    if (!ok || out_data !== e) begin
      errors++;
      $display("FAIL cfg_busy_data: got %h (valid seen %0d) want %h", out_data, ok, e);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== e) begin
      errors++;
      $display("FAIL out_hold: got valid=%b data=%h want valid=0 data=%h", out_valid, out_data, e);
    end
    repeat (2) tick();
    // rejected in the same cycle as an operand; operand uses old q
    p = rand_p();
    in_valid = 1'b1;
    in_data  = p;
    cfg_we   = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    checks++;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_inval_err: got %b want 1", cfg_err); end
    wait_out(ok);
    e = ref_mod(p, model_q);
    checks++;
    if (!ok || out_data !== e) begin
      errors++;
      $display("FAIL cfg_inval_data: got %h (valid seen %0d) want %h", out_data, ok, e);
    end
    repeat (2) tick();
    // accepted when idle; new q takes effect
    load_cfg(QB);
    p = rand_p();
    in_valid = 1'b1;
    in_data  = p;
    tick();
    in_valid = 1'b0;
    wait_out(ok);
    e = ref_mod(p, QB);
    checks++;
    if (!ok || out_data !== e) begin
      errors++;
      $display("FAIL cfg_new_q_data: got %h (valid seen %0d) want %h", out_data, ok, e);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = rand_p();
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_q = '0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got valid=%b data=%h busy=%b want 0/0/0", out_valid, out_data, busy);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_ghost cycle %0d: got %b want 0", i, out_valid); end
    end
    // modulus was cleared, so results read back as 0 until reloaded
    test_unconfigured("reset_mid_unconf");
  endtask

`ifdef BARRETT_TAG_EN
  task automatic test_tag();
    logic [7:0] tag_q[$];
    logic [DW-1:0] exp_q[$];
    int         due_q[$];
    bit         exp_v;
    logic [7:0] t;
    logic [DW-1:0] e;
    logic [2*DW-1:0] p;
    for (int c = 0; c < 256 + 6; c++) begin
      if (c < 256) begin
        p = rand_p();
        in_valid = 1'b1;
        in_data  = p;
        in_tag   = 8'(c);
        tag_q.push_back(8'(c));
        exp_q.push_back(ref_mod(p, model_q));
        due_q.push_back(cyc + 4);
      end else begin
        in_valid = 1'b0;
        in_tag   = $urandom_range(0, 255);
      end
      tick();
      exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
      checks++;
      if (out_valid !== exp_v) begin errors++; $display("FAIL tag_valid step %0d: got %b want %b", c, out_valid, exp_v); end
      if (exp_v) begin
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        checks++;
        if (out_tag !== t || out_data !== e) begin
          errors++;
          $display("FAIL tag_data step %0d: got tag=%h data=%h want tag=%h data=%h", c, out_tag, out_data, t, e);
        end
      end
    end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unconfigured("unconf");
    test_latency();
    test_known();
    test_back_to_back();
    test_cfg_busy();
    load_cfg(QA);
    test_back_to_back();
    test_reset_mid();
    load_cfg(QA);
`ifdef BARRETT_TAG_EN
    test_tag();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
